// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives instruction memory and fills the IF/ID register.
// Handles hazard stalls, one-bubble branch redirects and an end-of-program halt.
module inst_fetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int unsigned MEM_BYTES = 156,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] inst_address,
  input  logic [31:0] instruction,
  output logic [63:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned COUNT_W = 32;
  localparam logic [PC_W-1:0]    MEM_END   = PC_W'(MEM_BYTES);
  localparam logic [PC_W-1:0]    PC_STEP   = PC_W'(4);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [PC_W-1:0]      if_pc_q, if_pc_d;
  logic [INSTR_W-1:0]   if_instr_q, if_instr_d;
  logic                 if_valid_q, if_valid_d;
  logic                 halted_q, fault_q;
  logic [COUNT_W-1:0]   count_q, count_d;

  // Zero-wait memory: the address is the live PC.
  assign inst_address   = pc_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = if_instr_q;
  assign if_valid       = if_valid_q;
  assign halted         = halted_q;
  assign fault          = fault_q;
  assign fetch_count    = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_WORD;
      if_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      halted_q   <= (state_d == HALT);
      fault_q    <= (state_d == FAULT);
      count_q    <= count_d;
    end
  end

  // Next-state and IF/ID update; redirect beats stall, stall beats halt/capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    count_d    = count_q;

    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          state_d    = FAULT;
          if_valid_d = 1'b0;
          if_instr_d = NOP_WORD;
        end else if (branch_taken) begin
          pc_d       = branch_target;
          if_pc_d    = '0;
          if_valid_d = 1'b0;
          if_instr_d = NOP_WORD;
        end else if (stall) begin
          state_d = RUN;
        end else if (pc_q >= MEM_END) begin
          state_d    = HALT;
          if_valid_d = 1'b0;
          if_instr_d = NOP_WORD;
        end else begin
          if_instr_d = instruction;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + PC_STEP;
          count_d    = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_W'(1);
        end
      end
      HALT, FAULT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch sequencer for the RISC-V pipeline. It owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned word into the IF/ID register. It applies hazard stalls and branch redirects with a one-bubble flush, and stops fetching cleanly when the PC runs past the loaded program. It sits between the hazard/branch logic and the decode stage.

## Interface
- RESET_PC, 64'd0, PC loaded on reset
- MEM_BYTES, 156, size of the loaded program in bytes; a PC ≥ MEM_BYTES is past the end
- NOP_WORD, 32'h00000013, bubble word (addi x0,x0,0)

Ports:
- clk  in  1  sole clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit request to hold PC and IF/ID
- branch_taken  in  1  redirect request from the branch-resolution stage
- branch_target  in  64  redirect byte address
- inst_address  out  64  byte address to instruction memory, combinational copy of pc
- instruction  in  32  word returned by memory for inst_address, same cycle
- if_pc  out  64  PC of the word held in IF/ID
- if_instruction  out  32  IF/ID instruction
- if_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch has stopped at end of program
- fault  out  1  misaligned redirect detected
- fetch_count  out  32  number of valid captures, saturating

## Operation
- Reset values: pc=RESET_PC, state=BOOT, if_pc=0, if_instruction=NOP_WORD, if_valid=0, halted=0, fault=0, fetch_count=0.
- States and edges:
  - BOOT→RUN unconditionally; no capture, if_valid stays 0; stall and branch inputs ignored.
  - RUN: see priority list below.
  - HALT: terminal until reset; halted=1.
  - FAULT: terminal until reset; fault=1.
- RUN priority at each edge, highest first:
  1. branch_taken with branch_target[1:0]≠0 → FAULT, if_valid←0, if_instruction←NOP_WORD, pc unchanged.
  2. branch_taken, aligned → pc←branch_target, if_valid←0, if_instruction←NOP_WORD, if_pc←0. This is a flush and overrides stall.
  3. stall → pc and all if_* held, fetch_count held.
  4. pc ≥ MEM_BYTES → HALT, if_valid←0, if_instruction←NOP_WORD.
  5. Otherwise capture: if_instruction←instruction, if_pc←pc, if_valid←1, pc←pc+4 (64-bit wrap), fetch_count←fetch_count+1 (holds at 32'hFFFFFFFF).
- A redirect to a target ≥ MEM_BYTES is accepted; the next unstalled edge enters HALT via rule 4.
- In HALT/FAULT: pc, if_pc, fetch_count frozen; if_valid=0; inputs ignored.
- halted and fault are mutually exclusive.

## Timing
- inst_address = pc combinationally; the memory answer is sampled on the same edge (zero-wait fetch).
- After reset deasserts: edge 1 BOOT→RUN; edge 2 is the first capture (if_pc=RESET_PC, if_valid=1). Steady throughput is 1 instruction/cycle.
- Redirect penalty is exactly one bubble. The target instruction is valid in IF/ID on the second edge after branch_taken is sampled.
- Reset asserted in any state, including mid-stall or HALT, returns to reset values on that edge.

## Test plan
- Reset, 5 free-run cycles with no stall/branch → if_pc sequence 0,4,8,12 from edge 2; fetch_count=4 after edge 5; word at if_pc=4 is 32'h00F00713.
- stall high for 3 cycles while if_pc=8 → if_pc=8 and inst_address=12 held; on release the next capture is if_pc=12; fetch_count does not advance during the stall.
- branch_taken=1, target=0x40, same cycle as stall=1 → branch wins; next edge if_valid=0 with NOP_WORD; following edge if_pc=0x40, if_valid=1.
- Redirect to 0x98 → capture at 0x98 (32'h00000013); next edge pc=0x9C≥156 → HALT; halted=1, if_valid=0; a later branch_taken is ignored.
- branch_taken with target=0x42 → FAULT, fault=1, halted=0; then assert reset for 1 cycle → all outputs return to reset values and fetch restarts at 0.
- Force fetch_count to 32'hFFFFFFFF, then capture → stays 32'hFFFFFFFF.
